keypad_scanner: RTL and testbench

- Front end for the safe controller: scans a 4x4 active-low matrix keypad, synchronises and debounces the columns, and encodes the pressed key to a 4-bit code.
- Presents that code on keypad[3:0] with a confirm strobe, which the safe controller samples on the rising edge of confirm.
- Replaces the manual switch-plus-button entry: one physical key press produces exactly one confirm pulse.

---
 rtl/keypad_pkg.sv | 41 ++++
 rtl/keypad_if.sv | 14 +
 rtl/keypad_col_sync.sv | 24 ++
 rtl/keypad_scanner.sv | 148 ++++++++++++++
 tb/tb_keypad_scanner.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int         ROWS       = 4;
    localparam int         COLS       = 4;
    localparam logic [3:0] KEY_RELOCK = 4'hF;

    typedef enum logic [2:0] {
        SCAN,
        DEBOUNCE,
        LOAD,
        STROBE,
        RELEASE
    } scan_state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } col_hit_t;

    function automatic logic [3:0] enc_key(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

    // A key counts only when exactly one column is pulled low.
    function automatic col_hit_t one_low(input logic [COLS-1:0] col);
        col_hit_t hit;
        int       lows;
        hit  = '0;
        lows = 0;
        for (int c = 0; c < COLS; c++) begin
            if (!col[c]) begin
                lows++;
                hit.idx = 2'(c);
            end
        end
        hit.valid = (lows == 1);
        return hit;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad-side and controller-side signals of the scanner, grouped as one bundle.
interface keypad_if;
    import keypad_pkg::*;

    logic [COLS-1:0] col_in;
    logic [ROWS-1:0] row_out;
    logic [3:0]      keypad;
    logic            confirm;
    logic            key_down;

    modport master (input col_in, output row_out, keypad, confirm, key_down);
    modport slave  (output col_in, input row_out, keypad, confirm, key_down);

endinterface

// File: rtl/keypad_col_sync.sv
// Two-flop synchroniser for the asynchronous column lines; idles at all-released.
module keypad_col_sync
    import keypad_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [COLS-1:0] d,
    output logic [COLS-1:0] q
);

    logic [COLS-1:0] meta;

    // NOTE: non-blocking assignments make both stages shift on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad, debounces press and release, and issues one
// confirm strobe with a stable 4-bit code per physical key press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter int DEBOUNCE_SCANS = 10,
    parameter int CONFIRM_WIDTH  = 4
) (
    input logic       clk,
    input logic       reset,
    keypad_if.master  bus
);

    localparam int TICK_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DEB_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam int PULSE_W = $clog2(CONFIRM_WIDTH + 1);

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(CLK_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_SCANS);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(CONFIRM_WIDTH);

    logic [COLS-1:0]    col_s;
    logic [TICK_W-1:0]  tick;
    logic               sample;
    scan_state_t        state;
    logic [1:0]         row_idx;
    logic [3:0]         code;
    logic [DEB_W-1:0]   deb_cnt;
    logic [DEB_W-1:0]   rel_cnt;
    logic [PULSE_W-1:0] pulse_cnt;
    logic [3:0]         keypad_r;
    logic               confirm_r;
    logic               key_down_r;
    col_hit_t           hit;

    keypad_col_sync u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.col_in),
        .q     (col_s)
    );

    assign sample = (tick == TICK_LAST);
    assign hit    = one_low(col_s);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick <= '0;
        end else if (sample) begin
            tick <= '0;
        end else begin
            tick <= tick + TICK_W'(1);
        end
    end

    // Row stays frozen from first detection until the release is debounced.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SCAN;
            row_idx    <= '0;
            code       <= '0;
            deb_cnt    <= '0;
            rel_cnt    <= '0;
            pulse_cnt  <= '0;
            keypad_r   <= '0;
            confirm_r  <= 1'b0;
            key_down_r <= 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    if (sample) begin
                        if (hit.valid) begin
                            code <= enc_key(row_idx, hit.idx);
                            if (DEB_LAST == DEB_W'(1)) begin
                                state <= LOAD;
                            end else begin
                                deb_cnt <= DEB_W'(1);
                                state   <= DEBOUNCE;
                            end
                        end else begin
                            row_idx <= row_idx + 2'd1;
                        end
                    end
                end

                DEBOUNCE: begin
                    if (sample) begin
                        if (hit.valid && (hit.idx == code[1:0])) begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                            if ((deb_cnt + DEB_W'(1)) == DEB_LAST) begin
                                state <= LOAD;
                            end
                        end else begin
                            deb_cnt <= '0;
                            row_idx <= row_idx + 2'd1;
                            state   <= SCAN;
                        end
                    end
                end

                LOAD: begin
                    keypad_r   <= code;
                    key_down_r <= 1'b1;
                    pulse_cnt  <= '0;
                    deb_cnt    <= '0;
                    rel_cnt    <= '0;
                    state      <= STROBE;
                end

                STROBE: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        confirm_r <= 1'b0;
                        state     <= RELEASE;
                    end else begin
                        confirm_r <= 1'b1;
                        pulse_cnt <= pulse_cnt + PULSE_W'(1);
                    end
                end

                RELEASE: begin
                    if (sample) begin
                        if (col_s == '1) begin
                            if ((rel_cnt + DEB_W'(1)) == DEB_LAST) begin
                                rel_cnt    <= '0;
                                key_down_r <= 1'b0;
                                row_idx    <= row_idx + 2'd1;
                                state      <= SCAN;
                            end else begin
                                rel_cnt <= rel_cnt + DEB_W'(1);
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end
                end

                default: state <= SCAN;
            endcase
        end
    end

    assign bus.row_out  = ~(ROWS'(1) << row_idx);
    assign bus.keypad   = keypad_r;
    assign bus.confirm  = confirm_r;
    assign bus.key_down = key_down_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 switch matrix.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int CW = 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] keys  = '0;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    logic conf_q = 1'b0;

    keypad_if bus ();

    keypad_scanner #(
        .CLK_DIV        (4),
        .DEBOUNCE_SCANS (3),
        .CONFIRM_WIDTH  (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Pressed key (r,c) pulls column c low only while row r is driven low.
    always_comb begin
        bus.col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r+c] && !bus.row_out[r]) bus.col_in[c] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        conf_q <= bus.confirm;
        if (bus.confirm && !conf_q) pulses <= pulses + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      name;
        logic [15:0] keys;
        bit         exp_confirm;
        logic [3:0] exp_code;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_confirm(input int budget, output bit found, output logic [3:0] kp_before);
        logic [3:0] kp_prev;
        found     = 1'b0;
        kp_before = 'x;
        for (int i = 0; i < budget; i++) begin
            kp_prev = bus.keypad;
            cyc(1);
            if (bus.confirm) begin
                found     = 1'b1;
                kp_before = kp_prev;
                break;
            end
        end
    endtask

    task automatic measure_width(output int w);
        w = 0;
        while (bus.confirm && w < 20) begin
            w++;
            cyc(1);
        end
    endtask

    task automatic wait_key_up(input int budget, output int n);
        n = 0;
        while (bus.key_down && n < budget) begin
            cyc(1);
            n++;
        end
    endtask

    // Press, expect one pulse carrying exp_code, release, expect key_down to drop.
    task automatic press_and_release(input string name, input logic [15:0] k, input logic [3:0] exp_code);
        bit         found;
        logic [3:0] kp_before;
        int         w;
        int         n;
        keys = k;
        wait_confirm(120, found, kp_before);
        check({name, "_confirm_seen"}, found, 1);
        if (found) begin
            check({name, "_keypad_before_confirm"}, kp_before, exp_code);
            check({name, "_key_down"}, bus.key_down, 1);
            measure_width(w);
            check({name, "_confirm_width"}, w, CW);
            check({name, "_keypad_hold"}, bus.keypad, exp_code);
        end
        keys = '0;
        wait_key_up(40, n);
        check_range({name, "_release_latency"}, n, 11, 14);
    endtask

    initial begin
        logic [3:0] row_seq [4];
        logic [3:0] kp_log [17];
        logic       cf_log [17];
        bit         found;
        logic [3:0] kp_before;
        int         p0;
        int         w;
        int         n;

        row_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        vecs[0] = '{"r2c1",          16'h0200, 1'b1, 4'h9};
        vecs[1] = '{"two_cols_r0",   16'h0003, 1'b0, 4'h9};
        vecs[2] = '{"r1c3",          16'h0080, 1'b1, 4'h7};
        vecs[3] = '{"three_cols_r1", 16'h00E0, 1'b0, 4'h7};
        vecs[4] = '{"r3c2",          16'h4000, 1'b1, 4'hE};
        vecs[5] = '{"r3c2_repeat",   16'h4000, 1'b1, 4'hE};
        vecs[6] = '{"r0c0",          16'h0001, 1'b1, 4'h0};

        // Reset state and idle scan.
        cyc(2);
        check("reset_row_out", bus.row_out, 4'b1110);
        check("reset_keypad", bus.keypad, 4'h0);
        check("reset_confirm", bus.confirm, 0);
        check("reset_key_down", bus.key_down, 0);
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            check($sformatf("idle_row_out_cycle%0d", k), bus.row_out, row_seq[(k / 4) % 4]);
        end
        check("idle_no_confirm", pulses, 0);

        // Table-driven presses.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].exp_confirm) begin
                press_and_release(vecs[i].name, vecs[i].keys, vecs[i].exp_code);
            end else begin
                p0   = pulses;
                keys = vecs[i].keys;
                wait_confirm(100, found, kp_before);
                check({vecs[i].name, "_no_confirm"}, found, 0);
                check({vecs[i].name, "_keypad_unchanged"}, bus.keypad, vecs[i].exp_code);
                check({vecs[i].name, "_no_key_down"}, bus.key_down, 0);
                keys = '0;
                cyc(8);
                check({vecs[i].name, "_pulse_count"}, pulses, p0);
            end
        end

        // Bouncing contact: closed on alternate samples only, then stable.
        p0 = pulses;
        for (int i = 0; i < 8; i++) begin
            keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            cyc(4);
        end
        check("bounce_no_confirm", pulses, p0);
        press_and_release("bounce_settled", 16'h0200, 4'h9);
        cyc(20);
        check("bounce_single_pulse", pulses, p0 + 1);

        // Relock key held, second key added, both released, second pressed again.
        keys = 16'h8000;
        wait_confirm(120, found, kp_before);
        check("relock_confirm_seen", found, 1);
        check("relock_keypad", kp_before, 4'hF);
        measure_width(w);
        check("relock_width", w, CW);
        p0   = pulses;
        keys = 16'h8001;
        cyc(60);
        check("second_key_held_no_confirm", pulses, p0);
        check("second_key_held_key_down", bus.key_down, 1);
        keys = '0;
        wait_key_up(40, n);
        check_range("relock_release_latency", n, 11, 14);
        cyc(60);
        check("both_released_no_confirm", pulses, p0);
        press_and_release("second_key_again", 16'h0001, 4'h0);

        // Reset in the middle of the strobe, key held throughout.
        keys = 16'h0004;
        wait_confirm(120, found, kp_before);
        check("pre_reset_confirm_seen", found, 1);
        reset = 1'b1;
        #1;
        check("midreset_confirm", bus.confirm, 0);
        check("midreset_keypad", bus.keypad, 4'h0);
        check("midreset_row_out", bus.row_out, 4'b1110);
        check("midreset_key_down", bus.key_down, 0);
        cyc(2);
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc(1);
            kp_log[k] = bus.keypad;
            cf_log[k] = bus.confirm;
        end
        check("reissue_keypad_c12", kp_log[12], 4'h0);
        check("reissue_keypad_c13", kp_log[13], 4'h2);
        check("reissue_confirm_c13", cf_log[13], 0);
        check("reissue_confirm_c14", cf_log[14], 1);
        check("reissue_confirm_c15", cf_log[15], 1);
        check("reissue_confirm_c16", cf_log[16], 0);
        keys = '0;
        wait_key_up(40, n);
        check("reissue_key_released", bus.key_down, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
